// File: rtl/safe_seq_pkg.sv
// Shared types for the safe-mode sequencer: FSM state encoding and bus-mode constants.
// No logic; imported by the timer and the sequencer top.
package safe_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SYNC_IRQ = 3'd1,
      ST_SWITCH   = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_ABORT    = 3'd4
   } seq_state_e;

   localparam logic MODE_INDEP  = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/safe_seq_timer.sv
// Wait-state timer: saturating up-counter with clear/load/enable; tc_o flags TIMEOUT_CYCLES-1.
// Counter updates one cycle after its controls; no handshake, it never stalls.
module safe_seq_timer
   import safe_seq_pkg::*;
#(
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Holding at CNT_MAX keeps tc_o asserted instead of wrapping back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/safe_mode_sequencer.sv
// Request-driven independent <-> single-bus mode sequencer: IRQ both cores, wait for WFI, flip bus, wait ack.
// Minimum sequence: request to done_o in 4 cycles; requests while busy_o is high are dropped.
module safe_mode_sequencer
   import safe_seq_pkg::*;
#(
   parameter int NHARTS         = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mode_req_i,
   input  logic              mode_target_i,
   input  logic              master_core_i,
   input  logic [NHARTS-1:0] sleep_i,
   input  logic              intc_ack_i,
   output logic [NHARTS-1:0] sync_irq_o,
   output logic [NHARTS-1:0] halt_req_o,
   output logic              single_bus_o,
   output logic              master_core_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o
);

   if (NHARTS != 2) begin : g_bad_nharts
      $error("safe_mode_sequencer: only NHARTS == 2 is supported");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("safe_mode_sequencer: TIMEOUT_CYCLES must be >= 2");
   end

   seq_state_e        state_q;
   logic              mode_q, master_q, target_q, pend_master_q;
   logic              prev_mode_q, prev_master_q;
   logic [NHARTS-1:0] sync_irq_q, halt_req_q;
   logic              busy_q, done_q, timeout_q;
   logic              all_asleep, tmr_tc, stay;

   assign all_asleep = &sleep_i;

   // The timer runs only while a wait state is held; any state change restarts it from zero.
   always_comb begin
      stay = 1'b0;
      if (state_q == ST_SYNC_IRQ) begin
         stay = !all_asleep && !tmr_tc;
      end else if (state_q == ST_WAIT_ACK) begin
         stay = !intc_ack_i && !tmr_tc;
      end
   end

   safe_seq_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (!stay),
      .en_i       (stay),
      .load_i     (1'b0),
      .load_val_i ('0),
      .tc_o       (tmr_tc)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         mode_q        <= MODE_INDEP;
         master_q      <= 1'b0;
         target_q      <= MODE_INDEP;
         pend_master_q <= 1'b0;
         prev_mode_q   <= MODE_INDEP;
         prev_master_q <= 1'b0;
         sync_irq_q    <= '0;
         halt_req_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         halt_req_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (mode_req_i) begin
                  if (mode_target_i == mode_q) begin
                     done_q <= 1'b1;
                  end else begin
                     target_q      <= mode_target_i;
                     pend_master_q <= (mode_target_i == MODE_SINGLE) ? master_core_i : master_q;
                     prev_mode_q   <= mode_q;
                     prev_master_q <= master_q;
                     sync_irq_q    <= '1;
                     busy_q        <= 1'b1;
                     state_q       <= ST_SYNC_IRQ;
                  end
               end
            end
            ST_SYNC_IRQ: begin
               if (all_asleep) begin
                  sync_irq_q <= '0;
                  state_q    <= ST_SWITCH;
               end else if (tmr_tc) begin
                  sync_irq_q <= '0;
                  timeout_q  <= 1'b1;
                  halt_req_q <= '1;
                  state_q    <= ST_ABORT;
               end
            end
            ST_SWITCH: begin
               mode_q   <= target_q;
               master_q <= pend_master_q;
               state_q  <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (intc_ack_i) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (tmr_tc) begin
                  timeout_q  <= 1'b1;
                  halt_req_q <= '1;
                  state_q    <= ST_ABORT;
               end
            end
            ST_ABORT: begin
               mode_q   <= prev_mode_q;
               master_q <= prev_master_q;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sync_irq_o    = sync_irq_q;
   assign halt_req_o    = halt_req_q;
   assign single_bus_o  = mode_q;
   assign master_core_o = master_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_safe_mode_sequencer.sv
// Directed scenarios for the safe-mode sequencer, checked every cycle against a transaction-level model.
module tb_safe_mode_sequencer;

   localparam int T  = 8;
   localparam int N  = 40;
   localparam int NS = 7;
   localparam int B_SYNC = 0, B_HALT = 1, B_BUSY = 2, B_DONE = 3, B_TO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0, mode_req = 1'b0, mode_target = 1'b0, master_core = 1'b0, intc_ack = 1'b0;
   logic [1:0] sleep = 2'b00;
   logic [1:0] sync_irq, halt_req;
   logic       single_bus, master_core_out, busy, done, timeout;

   always #5 clk = ~clk;

   safe_mode_sequencer #(
      .NHARTS         (2),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .mode_req_i    (mode_req),
      .mode_target_i (mode_target),
      .master_core_i (master_core),
      .sleep_i       (sleep),
      .intc_ack_i    (intc_ack),
      .sync_irq_o    (sync_irq),
      .halt_req_o    (halt_req),
      .single_bus_o  (single_bus),
      .master_core_o (master_core_out),
      .busy_o        (busy),
      .done_o        (done),
      .timeout_o     (timeout)
   );

   // Stimulus per cycle and expected outputs per cycle.
   logic       s_rst[N], s_req[N], s_tgt[N], s_mst[N], s_ack[N];
   logic [1:0] s_slp[N];
   logic [4:0] e_pl[N];
   logic       e_bus[N], e_mst[N];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int cyc, input logic [1:0] act, input logic [1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   function automatic void mark(input int b, input int lo, input int hi, input int lim);
      for (int c = lo; c <= hi; c++) begin
         if (c < N && c <= lim) e_pl[c][b] = 1'b1;
      end
   endfunction

   function automatic void fill_mode(input int from, input logic b, input logic m);
      for (int c = from; c < N; c++) begin
         e_bus[c] = b;
         e_mst[c] = m;
      end
   endfunction

   // Walks the stimulus one request at a time and paints the output timeline from the timing rules.
   function automatic void predict();
      int   t, r, s, a, ab, nxt;
      logic mode, mst, nm;
      for (int c = 0; c < N; c++) begin
         e_pl[c]  = '0;
         e_bus[c] = 1'b0;
         e_mst[c] = 1'b0;
      end
      mode = 1'b0;
      mst  = 1'b0;
      t    = 0;
      while (t < N) begin
         if (s_rst[t]) begin
            mode = 1'b0;
            mst  = 1'b0;
            fill_mode(t + 1, 1'b0, 1'b0);
            t++;
         end else if (!s_req[t]) begin
            t++;
         end else begin
            r = N;
            for (int c = N - 1; c > t; c--) if (s_rst[c]) r = c;
            if (s_tgt[t] == mode) begin
               mark(B_DONE, t + 1, t + 1, r);
               t++;
            end else begin
               nm = s_tgt[t] ? s_mst[t] : mst;
               s  = -1;
               for (int c = t + 1; c <= t + T && c < N; c++) begin
                  if (s < 0 && s_slp[c] == 2'b11) s = c;
               end
               if (s < 0) begin
                  ab = t + 1 + T;
                  mark(B_SYNC, t + 1, ab - 1, r);
                  mark(B_BUSY, t + 1, ab, r);
                  mark(B_HALT, ab, ab, r);
                  mark(B_TO, ab, ab, r);
                  nxt = ab + 1;
               end else begin
                  mark(B_SYNC, t + 1, s, r);
                  fill_mode(s + 2, s_tgt[t], nm);
                  a = -1;
                  for (int c = s + 2; c <= s + 1 + T && c < N; c++) begin
                     if (a < 0 && s_ack[c]) a = c;
                  end
                  if (a >= 0) begin
                     mark(B_BUSY, t + 1, a, r);
                     mark(B_DONE, a + 1, a + 1, r);
                     mode = s_tgt[t];
                     mst  = nm;
                     nxt  = a + 1;
                  end else begin
                     ab = s + 2 + T;
                     mark(B_BUSY, t + 1, ab, r);
                     mark(B_HALT, ab, ab, r);
                     mark(B_TO, ab, ab, r);
                     fill_mode(ab + 1, mode, mst);
                     nxt = ab + 1;
                  end
               end
               t = (r < nxt) ? r : nxt;
            end
         end
      end
   endfunction

   task automatic req_at(input int c, input logic tgt, input logic mst);
      s_req[c] = 1'b1;
      s_tgt[c] = tgt;
      s_mst[c] = mst;
   endtask

   task automatic sleep_rng(input int lo, input int hi, input logic [1:0] v);
      for (int c = lo; c <= hi; c++) s_slp[c] = v;
   endtask

   task automatic build(input int sc);
      for (int c = 0; c < N; c++) begin
         s_rst[c] = 1'b0; s_req[c] = 1'b0; s_tgt[c] = 1'b0;
         s_mst[c] = 1'b0; s_ack[c] = 1'b0; s_slp[c] = 2'b00;
      end
      s_rst[0] = 1'b1;
      case (sc)
         0: begin  // basic enter single-bus, master 0
            req_at(1, 1'b1, 1'b0); sleep_rng(3, N - 1, 2'b11); s_ack[6] = 1'b1;
         end
         1: begin  // enter with master 1, then leave; sleep and ack coincide in SYNC
            req_at(1, 1'b1, 1'b1); sleep_rng(3, 7, 2'b11); s_ack[6] = 1'b1;
            req_at(10, 1'b0, 1'b0); sleep_rng(11, N - 1, 2'b11);
            s_ack[11] = 1'b1; s_ack[15] = 1'b1;
         end
         2: begin  // only core 0 sleeps, then a same-mode request
            req_at(1, 1'b1, 1'b1); sleep_rng(0, N - 1, 2'b01);
            req_at(12, 1'b0, 1'b0);
         end
         3: begin  // ack never arrives
            req_at(1, 1'b1, 1'b1); sleep_rng(2, N - 1, 2'b11);
         end
         4: begin  // requests while busy and master toggling, then exit
            req_at(1, 1'b1, 1'b1); req_at(3, 1'b0, 1'b0); req_at(4, 1'b1, 1'b0);
            for (int c = 5; c < 12; c++) s_mst[c] = c[0];
            sleep_rng(5, N - 1, 2'b11); s_ack[8] = 1'b1;
            req_at(12, 1'b0, 1'b0); s_ack[16] = 1'b1;
         end
         5: begin  // same-mode requests in both modes
            req_at(1, 1'b0, 1'b1); req_at(2, 1'b0, 1'b0);
            req_at(5, 1'b1, 1'b1); sleep_rng(6, N - 1, 2'b11); s_ack[9] = 1'b1;
            req_at(12, 1'b1, 1'b0);
         end
         default: begin  // reset mid-sequence, then a clean sequence
            req_at(1, 1'b1, 1'b1); sleep_rng(3, N - 1, 2'b11);
            s_rst[5] = 1'b1; s_ack[7] = 1'b1;
            req_at(9, 1'b1, 1'b0); s_ack[13] = 1'b1;
         end
      endcase
   endtask

   // Hand-computed points that anchor the model.
   task automatic pin(input int sc);
      case (sc)
         0: begin
            chk("pin0.sync@2", 2, {1'b0, e_pl[2][B_SYNC]}, 2'b01);
            chk("pin0.sync@3", 3, {1'b0, e_pl[3][B_SYNC]}, 2'b01);
            chk("pin0.sync@4", 4, {1'b0, e_pl[4][B_SYNC]}, 2'b00);
            chk("pin0.bus@4", 4, {1'b0, e_bus[4]}, 2'b00);
            chk("pin0.bus@5", 5, {1'b0, e_bus[5]}, 2'b01);
            chk("pin0.done@6", 6, {1'b0, e_pl[6][B_DONE]}, 2'b00);
            chk("pin0.done@7", 7, {1'b0, e_pl[7][B_DONE]}, 2'b01);
            chk("pin0.busy@7", 7, {1'b0, e_pl[7][B_BUSY]}, 2'b00);
         end
         2: begin
            chk("pin2.sync@9", 9, {1'b0, e_pl[9][B_SYNC]}, 2'b01);
            chk("pin2.to@10", 10, {1'b0, e_pl[10][B_TO]}, 2'b01);
            chk("pin2.done@13", 13, {1'b0, e_pl[13][B_DONE]}, 2'b01);
         end
         3: begin
            chk("pin3.bus@12", 12, {1'b0, e_bus[12]}, 2'b01);
            chk("pin3.bus@13", 13, {1'b0, e_bus[13]}, 2'b00);
            chk("pin3.halt@12", 12, {1'b0, e_pl[12][B_HALT]}, 2'b01);
         end
         6: begin
            chk("pin6.bus@6", 6, {1'b0, e_bus[6]}, 2'b00);
            chk("pin6.done@8", 8, {1'b0, e_pl[8][B_DONE]}, 2'b00);
            chk("pin6.done@14", 14, {1'b0, e_pl[14][B_DONE]}, 2'b01);
         end
         default: ;
      endcase
   endtask

   task automatic run(input int sc);
      build(sc);
      predict();
      pin(sc);
      for (int c = 0; c < N; c++) begin
         @(posedge clk);
         #1;
         rst         = s_rst[c];
         mode_req    = s_req[c];
         mode_target = s_tgt[c];
         master_core = s_mst[c];
         sleep       = s_slp[c];
         intc_ack    = s_ack[c];
         @(negedge clk);
         if (c > 0) begin
            chk($sformatf("s%0d.sync_irq", sc), c, sync_irq, {2{e_pl[c][B_SYNC]}});
            chk($sformatf("s%0d.halt_req", sc), c, halt_req, {2{e_pl[c][B_HALT]}});
            chk($sformatf("s%0d.busy", sc), c, {1'b0, busy}, {1'b0, e_pl[c][B_BUSY]});
            chk($sformatf("s%0d.done", sc), c, {1'b0, done}, {1'b0, e_pl[c][B_DONE]});
            chk($sformatf("s%0d.timeout", sc), c, {1'b0, timeout}, {1'b0, e_pl[c][B_TO]});
            chk($sformatf("s%0d.single_bus", sc), c, {1'b0, single_bus}, {1'b0, e_bus[c]});
            chk($sformatf("s%0d.master_core", sc), c, {1'b0, master_core_out}, {1'b0, e_mst[c]});
         end
      end
   endtask

   initial begin
      for (int sc = 0; sc < NS; sc++) run(sc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
